// File: rtl/muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider, one bit per cycle, with hardware fast path for div-by-zero/overflow.
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [1:0]      o_state
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_op;
    logic                r_sign_a, r_sign_b, r_valid;
    logic [XLEN-1:0]     r_mcand, r_div, r_quo, r_rem, r_result;
    logic [2*XLEN-1:0]   r_prod;

    logic                w_sa, w_sb, w_div0, w_ovf, w_fast, w_qbit, w_neg_p;
    logic [XLEN-1:0]     w_abs_a, w_abs_b, w_fast_res, w_diff, w_rem_nx, w_quo_nx;
    logic [XLEN-1:0]     w_quo_fix, w_rem_fix, w_final;
    logic [XLEN:0]       w_sum, w_shift;
    logic [2*XLEN-1:0]   w_prod_nx, w_prod_fix;

    // Request side: a request transfers on a rising edge where i_valid && o_ready && !i_flush.
    // Result side: o_result transfers on a rising edge where o_valid && i_ready.
    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_state  = r_state;

    always_comb begin
        w_sa    = i_op_a[XLEN-1] && (i_funct3 == F_MULH || i_funct3 == F_MULHSU ||
                                     i_funct3 == F_DIV  || i_funct3 == F_REM);
        w_sb    = i_op_b[XLEN-1] && (i_funct3 == F_MULH || i_funct3 == F_DIV || i_funct3 == F_REM);
        w_abs_a = w_sa ? -i_op_a : i_op_a;
        w_abs_b = w_sb ? -i_op_b : i_op_b;
        w_div0  = (i_op_b == '0);
        w_ovf   = (i_funct3 == F_DIV || i_funct3 == F_REM) && (i_op_a == MIN) && (i_op_b == '1);
        w_fast  = i_funct3[2] && (w_div0 || w_ovf);
        if (w_div0) w_fast_res = i_funct3[1] ? i_op_a : '1;
        else        w_fast_res = i_funct3[1] ? '0 : i_op_a;
    end

    always_comb begin
        w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_nx  = {w_sum, r_prod[XLEN-1:1]};
        // The shifted partial remainder carries one guard bit above XLEN.
        w_shift    = {r_rem, r_quo[XLEN-1]};
        w_qbit     = (w_shift >= {1'b0, r_div});
        w_diff     = w_shift[XLEN-1:0] - r_div;
        w_rem_nx   = w_qbit ? w_diff : w_shift[XLEN-1:0];
        w_quo_nx   = {r_quo[XLEN-2:0], w_qbit};
        w_neg_p    = (r_op == F_MULHSU) ? r_sign_a : (r_sign_a ^ r_sign_b);
        w_prod_fix = w_neg_p ? -w_prod_nx : w_prod_nx;
        w_quo_fix  = (r_sign_a ^ r_sign_b) ? -w_quo_nx : w_quo_nx;
        w_rem_fix  = r_sign_a ? -w_rem_nx : w_rem_nx;
        case (r_op)
            F_MUL:                     w_final = w_prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             w_final = w_quo_fix;
            default:                   w_final = w_rem_fix;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_valid  <= 1'b0;
            r_mcand  <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_valid) begin
                    r_op     <= i_funct3;
                    r_sign_a <= w_sa;
                    r_sign_b <= w_sb;
                    r_mcand  <= w_abs_a;
                    r_div    <= w_abs_b;
                    r_prod   <= {{XLEN{1'b0}}, w_abs_b};
                    r_quo    <= w_abs_a;
                    r_rem    <= '0;
                    r_cnt    <= '0;
                    if (w_fast) begin
                        r_result <= w_fast_res;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_prod <= w_prod_nx;
                    r_quo  <= w_quo_nx;
                    r_rem  <= w_rem_nx;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_result <= w_final;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // o_valid rises one edge after entering DONE and drops on the result handshake.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv (XLEN=32): directed cases, handshake timing,
// backpressure, flush, async reset, and random ops against an arithmetic reference model.
module tb_muldiv;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid, i_flush, i_ready;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_op_a, i_op_b;
    logic            o_ready, o_valid;
    logic [XLEN-1:0] o_result;
    logic [1:0]      o_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv #(.XLEN(XLEN)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct3(i_funct3), .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_state(o_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        bit              ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return ia / ib;
            3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
            3'd6: if (b == 0) return a; else if (ovf) return 32'd0; else return ia % ib;
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit ovf;
        ovf = (f3 == 3'd4 || f3 == 3'd6) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return (f3[2] && (b == 0 || ovf)) ? 1 : XLEN + 1;
    endfunction

    // Waits for o_ready, presents one request, returns #1 after the accept edge.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!o_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_accept", o_ready, 1);
        i_valid  = 1'b1;
        i_funct3 = f3;
        i_op_a   = a;
        i_op_b   = b;
        @(posedge clk); #1;
        i_valid  = 1'b0;
        i_funct3 = 3'($urandom);
        i_op_a   = $urandom;
        i_op_b   = $urandom;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        bit ready_low = 1'b1;
        while (!o_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (o_ready) ready_low = 1'b0;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, o_result, exp);
        check({tag, " ready_low"}, ready_low, 1);
    endtask

    task automatic drain(input string tag);
        i_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " valid_drop"}, o_valid, 0);
        check({tag, " ready_back"}, o_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
        start_op(f3, a, b);
        wait_result(tag, ref_model(f3, a, b), exp_latency(f3, a, b));
        drain(tag);
    endtask

    initial begin
        logic [31:0] bp_exp, held;
        bit          stable, seen_valid;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          hold;

        rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_funct3 = '0; i_op_a = '0; i_op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset o_ready", o_ready, 1);
        check("reset o_valid", o_valid, 0);
        check("reset o_result", o_result, 0);
        check("reset state", o_state, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with full timing checks.
        start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        wait_result("mul 7x-3", 32'hFFFF_FFEB, 33);
        @(posedge clk); #1;
        check("mul one-cycle valid", o_valid, 0);
        check("mul ready back", o_ready, 1);
        run_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu ff*ff",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu ff*ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div -7/2",     3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem -7/2",     3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu fe/2",    3'd5, 32'hFFFF_FFFE, 32'd2);
        run_op("remu 100/7",   3'd7, 32'd100, 32'd7);
        run_op("div 5/0",      3'd4, 32'd5, 32'd0);
        run_op("rem 5/0",      3'd6, 32'd5, 32'd0);
        run_op("div ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Backpressure: result held 10 cycles while a competing request is ignored.
        i_ready = 1'b0;
        bp_exp = 32'd142;
        start_op(3'd5, 32'd1000, 32'd7);
        wait_result("bp divu", bp_exp, 33);
        stable = 1'b1;
        i_valid = 1'b1; i_funct3 = 3'd0; i_op_a = 32'd3; i_op_b = 32'd4;
        repeat (10) begin
            @(posedge clk); #1;
            if (o_valid !== 1'b1 || o_result !== bp_exp || o_ready !== 1'b0 || o_state !== 2'd2)
                stable = 1'b0;
        end
        check("bp outputs stable", stable, 1);
        i_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release valid", o_valid, 0);
        check("bp release ready", o_ready, 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("bp next accepted", o_ready, 0);
        wait_result("bp next mul", 32'd12, 33);
        drain("bp next mul");

        // Flush at CALC counter 10.
        held = o_result;
        start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #1;
        check("flush pre state", o_state, 1);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("flush ready", o_ready, 1);
        check("flush state", o_state, 0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_valid) seen_valid = 1'b1;
        end
        check("flush no valid", seen_valid, 0);
        check("flush result held", o_result, held);
        i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0; i_op_a = 32'd9; i_op_b = 32'd9;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush blocks accept", o_ready, 1);

        // Asynchronous reset in the middle of CALC.
        start_op(3'd4, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid", o_valid, 0);
        check("async rst result", o_result, 0);
        check("async rst ready", o_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("after reset div", 3'd4, 32'd1000, 32'hFFFF_FFFD);

        // Random operations with random consumer delay.
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            hold = $urandom_range(0, 3);
            i_ready = (hold == 0);
            start_op(f3, a, b);
            wait_result("random", ref_model(f3, a, b), exp_latency(f3, a, b));
            repeat (hold) @(posedge clk);
            #0;
            drain("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
